// File: rtl/ldpc_float_pkg.sv
// Shared float32 constants, FSM states and helpers for the LDPC decoder.
// Used by the column sum calculator and the variable node extrinsic unit.
package ldpc_float_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int GUARD_W = 3;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_MAX_POS = 32'h7F7F_FFFF;
  localparam logic [31:0] FP_MAX_NEG = 32'hFF7F_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUB1,
    S_SUB2,
    S_SUB3,
    S_DONE
  } state_t;

  function automatic logic [4:0] lzc28(input logic [27:0] v);
    lzc28 = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (v[i]) lzc28 = 5'(27 - i);
    end
  endfunction

endpackage

// File: rtl/fp32_sub.sv
// Combinational float32 subtract y = a - b: flush-to-zero, truncation,
// saturation to the largest finite value instead of producing Inf.
module fp32_sub
  import ldpc_float_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  localparam int MW = MAN_W + 1 + GUARD_W;

  logic [31:0]      w_bn;
  logic [30:0]      w_mag_a;
  logic [30:0]      w_mag_b;
  logic             w_swap;
  logic [31:0]      w_l;
  logic [31:0]      w_s;
  logic [EXP_W-1:0] w_el;
  logic [EXP_W-1:0] w_es;
  logic [MW-1:0]    w_ml;
  logic [MW-1:0]    w_ms;
  logic [MW:0]      w_m;
  logic [4:0]       w_lz;
  logic [MW:0]      w_norm;
  logic [9:0]       w_e;
  logic [MAN_W-1:0] w_frac;

  always_comb begin
    w_bn    = {~b[31], b[30:0]};
    w_mag_a = (a[30:23] == '0) ? '0 : a[30:0];
    w_mag_b = (b[30:23] == '0) ? '0 : b[30:0];
    w_swap  = w_mag_b > w_mag_a;
    w_l     = w_swap ? {w_bn[31], w_mag_b} : {a[31], w_mag_a};
    w_s     = w_swap ? {a[31], w_mag_a} : {w_bn[31], w_mag_b};
    w_el    = w_l[MAN_W +: EXP_W];
    w_es    = w_s[MAN_W +: EXP_W];
    w_ml    = {(w_el != '0), w_l[MAN_W-1:0], {GUARD_W{1'b0}}};
    w_ms    = {(w_es != '0), w_s[MAN_W-1:0], {GUARD_W{1'b0}}};
    // no sticky bit: anything past the guard bits is simply lost
    w_ms    = w_ms >> (w_el - w_es);
    if (w_l[31] == w_s[31]) w_m = {1'b0, w_ml} + {1'b0, w_ms};
    else                    w_m = {1'b0, w_ml} - {1'b0, w_ms};
    w_lz    = lzc28(w_m);
    w_norm  = w_m << w_lz;
    w_frac  = MAN_W'(w_norm >> (GUARD_W + 1));
    w_e     = {2'b00, w_el} + 10'd1 - {5'd0, w_lz};
    if (w_m == '0)
      y = FP_ZERO;
    else if (w_e[9] || w_e == '0)
      y = FP_ZERO;
    else if (w_e > 10'(2 * BIAS))
      y = w_l[31] ? FP_MAX_NEG : FP_MAX_POS;
    else
      y = {w_l[31], w_e[EXP_W-1:0], w_frac};
  end

endmodule

// File: rtl/variable_node_extrinsic_unit.sv
// Extrinsic messages qi = T - ri for one column, computed serially over
// one shared subtractor, plus the hard decision bit (sign of T).
module variable_node_extrinsic_unit
  import ldpc_float_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] total,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic        hard_bit,
  output logic        busy,
  output logic        done
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_t;
  logic [31:0] r_r1;
  logic [31:0] r_r2;
  logic [31:0] r_r3;
  logic [31:0] r_q1;
  logic [31:0] r_q2;
  logic [31:0] r_q3;
  logic        r_hb;
  logic [31:0] w_b;
  logic [31:0] w_y;

  fp32_sub u_sub (
    .a (r_t),
    .b (w_b),
    .y (w_y)
  );

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_b    = r_r1;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_SUB1;
      S_SUB1: w_next = S_SUB2;
      S_SUB2: begin
        w_b    = r_r2;
        w_next = S_SUB3;
      end
      S_SUB3: begin
        w_b    = r_r3;
        w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_t  <= '0;
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
      r_q1 <= '0;
      r_q2 <= '0;
      r_q3 <= '0;
      r_hb <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_t  <= total;
        r_r1 <= r1;
        r_r2 <= r2;
        r_r3 <= r3;
      end
      if (r_state == S_SUB1) r_q1 <= w_y;
      if (r_state == S_SUB2) r_q2 <= w_y;
      if (r_state == S_SUB3) begin
        r_q3 <= w_y;
        r_hb <= r_t[31];
      end
    end
  end

  assign q1       = r_q1;
  assign q2       = r_q2;
  assign q3       = r_q3;
  assign hard_bit = r_hb;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_variable_node_extrinsic_unit.sv
// Directed bench with a done-driven scoreboard for the extrinsic unit.
// Expected results are hand-derived float32 constants.
module tb_variable_node_extrinsic_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] total, r1, r2, r3;
  logic [31:0] q1, q2, q3;
  logic        hard_bit, busy, done;

  typedef struct {
    logic [31:0] q1;
    logic [31:0] q2;
    logic [31:0] q3;
    logic        hb;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  variable_node_extrinsic_unit dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .total    (total),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .q1       (q1),
    .q2       (q2),
    .q3       (q3),
    .hard_bit (hard_bit),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL done: unexpected pulse got cycle %0d expected none", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("q1", q1, e.q1);
        chk("q2", q2, e.q2);
        chk("q3", q3, e.q3);
        chk("hard_bit", {31'd0, hard_bit}, {31'd0, e.hb});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic [31:0] e1, e2, e3, input logic hb,
                      input int c);
    exp_t e;
    e.q1 = e1; e.q2 = e2; e.q3 = e3; e.hb = hb; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic scramble();
    total = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({tag, "_drain"}, sb.size(), 0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_job(input string tag,
                         input logic [31:0] t, a, b, c,
                         input logic [31:0] e1, e2, e3, input logic hb);
    push(e1, e2, e3, hb, cyc + 4);
    total = t; r1 = a; r2 = b; r3 = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    drain(tag);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0;
    total = '0; r1 = '0; r2 = '0; r3 = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    chk("rst_q1", q1, 32'h0);
    chk("rst_q2", q2, 32'h0);
    chk("rst_q3", q3, 32'h0);
    chk("rst_hb", {31'd0, hard_bit}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    run_job("basic", 32'h41400000, 32'h40000000, 32'hC0800000,
            32'h3F000000, 32'h41200000, 32'h41800000, 32'h41380000, 1'b0);

    total = 32'h41400000; r1 = 32'h40000000;
    r2 = 32'hC0800000; r3 = 32'h3F000000;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 clr = 1'b1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 clr = 1'b0;
    chk("mid_q1", q1, 32'h0);
    chk("mid_q2", q2, 32'h0);
    chk("mid_q3", q3, 32'h0);
    chk("mid_hb", {31'd0, hard_bit}, 32'd0);
    chk("mid_busy0", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    run_job("cancel", 32'hC0400000, 32'hC0400000, 32'h3F800000,
            32'h00000000, 32'h00000000, 32'hC0800000, 32'hC0400000, 1'b1);

    run_job("sat", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000001,
            32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 1'b0);

    run_job("trunc", 32'h3F800000, 32'h33800000, 32'h3F800000,
            32'hBF800000, 32'h3F7FFFFF, 32'h00000000, 32'h40000000, 1'b0);

    push(32'h40000000, 32'h00000000, 32'hBF800000, 1'b0, cyc + 4);
    push(32'h40000000, 32'h00000000, 32'hBF800000, 1'b0, cyc + 9);
    total = 32'h40400000; r1 = 32'h3F800000;
    r2 = 32'h40400000; r3 = 32'h40800000;
    start = 1'b1;
    repeat (8) @(posedge clk);
    #1 start = 1'b0;
    drain("b2b");
    repeat (6) @(posedge clk);
    #1;

    push(32'hC1400000, 32'h00000000, 32'h40000000, 1'b1, cyc + 4);
    total = 32'hC1200000; r1 = 32'h40000000;
    r2 = 32'hC1200000; r3 = 32'hC1400000;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    scramble();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain("ign");
    repeat (6) @(posedge clk);
    #1;

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/variable_node_extrinsic_unit.md
# variable_node_extrinsic_unit

Downstream neighbour of the column sum calculator in the belief-propagation LDPC decoder. It takes the column total T (channel LLR plus all incoming check-to-variable messages r1..r3, IEEE-754 single) and produces the three extrinsic variable-to-check messages qi = T − ri. It also produces the hard decision bit for the column. A single shared floating-point subtractor is time-multiplexed over the three edges under a small FSM.

## Interface

Parameters:
- none. Widths are fixed at 32-bit single precision.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- total  in  32  column total T, float32
- r1, r2, r3  in  32 each  incoming messages, float32
- q1, q2, q3  out  32 each  extrinsic messages, registered
- hard_bit  out  1  1 when T is negative (sign bit of T), registered
- busy  out  1  high in SUB1, SUB2, SUB3 and DONE
- done  out  1  one-cycle completion pulse

## Operation

- States: IDLE, SUB1, SUB2, SUB3, DONE.
- IDLE with start=1:
  - latch total, r1, r2 and r3 into internal registers;
  - go to SUB1.
- IDLE with start=0: stay in IDLE.
- SUB1: q1 ← T − r1; go to SUB2.
- SUB2: q2 ← T − r2; go to SUB3.
- SUB3: q3 ← T − r3; hard_bit ← T[31]; go to DONE.
- DONE: done=1 (Moore output); go to IDLE unconditionally.
- start is ignored outside IDLE, including in DONE.
- Inputs may change freely after the latch edge.
- q1..q3 and hard_bit hold their values until overwritten by the next job.
- A q register that has already been written keeps its new value even if a later reset is not applied.

Float subtraction, fp32_sub(a, b) = a + (−b):
- Negate b by flipping its sign bit.
- Exponent field 0 is treated as ±0; denormals are flushed to zero.
- Exponent 255 (Inf/NaN) on input is out of scope; behaviour is unspecified.
- Restore the hidden 1 and align to the larger exponent. Shift the smaller mantissa right; bits shifted beyond 3 guard positions are dropped.
- Equal signs: add magnitudes. Otherwise subtract the smaller magnitude from the larger; the result takes the sign of the larger.
- Normalize with a leading-zero count.
- Rounding: truncate toward zero.
- Exact zero result → +0 (0x00000000).
- Result exponent < 1 → +0 with the sign preserved as 0.
- Result exponent > 254 → saturate to ±0x7F7FFFFF.
- The output exponent field is never 255.

## Timing

- Reset (clr=1 at a rising edge):
  - state ← IDLE;
  - q1..q3 = 0, hard_bit = 0, busy = 0, done = 0;
  - internal latches cleared.
  - clr overrides start and any in-flight job. A job interrupted mid-way produces no done pulse.
- Latency, with start sampled at edge E0:
  - q1 valid after E1;
  - q2 valid after E2;
  - q3 and hard_bit valid after E3;
  - done high from E3 to E4.
- Back-to-back jobs: the earliest next accept is at E5 (start held high through DONE is accepted at E5). Minimum job period is 5 cycles.
- fp32_sub is purely combinational, with one result per cycle. No multicycle paths.

## Structure

- ldpc_float_pkg holds:
  - field constants EXP_W=8, MAN_W=23, BIAS=127, GUARD_W=3;
  - FP_ZERO = 0x00000000, FP_MAX_POS = 0x7F7FFFFF, FP_MAX_NEG = 0xFF7FFFFF;
  - the FSM state enum.
- The package is shared with the column sum calculator, which reuses the same adder.
- Sub-module fp32_sub: combinational, inputs a and b, output y.
- The top level instantiates fp32_sub once. Its b-operand is selected by state (r1/r2/r3), and its a-operand is the latched T.

## Test plan

- Reset mid-job: start, then clr=1 during SUB2 → state IDLE, all outputs 0, no done pulse, busy=0 the next cycle.
- Basic job: T = 12.0 (0x41400000), r1 = 2.0 (0x40000000), r2 = −4.0 (0xC0800000), r3 = 0.5 (0x3F000000). Start → done exactly 3 cycles after the accept edge, with:
  - q1 = 0x41200000 (10.0);
  - q2 = 0x41800000 (16.0);
  - q3 = 0x41380000 (11.5);
  - hard_bit = 0.
- Cancellation and sign: T = −3.0 (0xC0400000), r1 = −3.0, r2 = 1.0, r3 = 0 → q1 = 0x00000000, q2 = 0xC0800000 (−4.0), q3 = 0xC0400000, hard_bit = 1.
- Saturation and flush: T = 0x7F7FFFFF, r1 = 0xFF7FFFFF → q1 = 0x7F7FFFFF. A denormal r2 = 0x00000001 → q2 = T.
- Handshake: start held high for 8 cycles → exactly two done pulses, at cycles 3 and 8 after the first accept. start pulsed during SUB2 → ignored.
- Truncation: T = 1.0, r1 = 2^−24 (0x33800000) → q1 = 0x3F7FFFFF (round toward zero, not 1.0).
